// File: rtl/bus_grant_arbiter_pkg.sv
// Shared definitions for the bus grant arbiter slice.
//   - FSM state encodings (IDLE / GRANT / TURN)
//   - Width of the grant word that feeds the 32-to-5 bus encoder
//   - Owner index width and the encoder "no driver" code
//   - Helper that builds a 32-bit one-hot grant word from an owner index
package bus_grant_arbiter_pkg;

    localparam int GRANT_W = 32;
    localparam int OWNER_W = 5;

    // Encoder code meaning "nobody drives the bus" (all-zero grant word).
    localparam logic [OWNER_W-1:0] NO_DRIVER = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // One-hot grant word; the shift is done at the full encoder width so
    // that no bit beyond the owner index can ever be produced.
    function automatic logic [GRANT_W-1:0] onehot_grant(input logic [OWNER_W-1:0] idx);
        onehot_grant = {{(GRANT_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Round-robin pick: combinational rotate-and-priority search.
// Returns the first set request at or above ptr, wrapping modulo NUM_SRC.
// Ports:
//   req   in  NUM_SRC  request vector
//   ptr   in  IDX_W    search start index (always < NUM_SRC)
//   idx   out IDX_W    index of the selected requester (0 when none)
//   found out 1        a requester was selected
module bus_grant_arbiter_rr_pick #(
    parameter int NUM_SRC = 23,
    parameter int IDX_W   = 5
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // One spare bit so that k + NUM_SRC - ptr never overflows.
    logic [IDX_W:0] ptr_ext_s;
    logic [IDX_W:0] k_s;
    logic [IDX_W:0] dist_s;
    logic [IDX_W:0] best_s;

    assign ptr_ext_s = {1'b0, ptr};

    // Every source computes its rotated distance from ptr; the requesting
    // source with the smallest distance wins. Iterating over constant source
    // indices keeps all request-bit selects static.
    always_comb begin
        idx    = {IDX_W{1'b0}};
        found  = 1'b0;
        best_s = {(IDX_W+1){1'b1}};
        k_s    = {(IDX_W+1){1'b0}};
        dist_s = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            k_s = (IDX_W+1)'(k);
            if (k_s >= ptr_ext_s) begin
                dist_s = k_s - ptr_ext_s;
            end else begin
                dist_s = k_s + (IDX_W+1)'(NUM_SRC) - ptr_ext_s;
            end
            if (req[k] && (dist_s < best_s)) begin
                best_s = dist_s;
                idx    = IDX_W'(k);
                found  = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Sequential round-robin bus arbiter feeding the 32-to-5 bus encoder.
// Grants one source at a time with a registered one-hot grant word, forces a
// release after MAX_HOLD cycles unless lock is held, and always inserts one
// dead (TURN) cycle between owners so two sources never drive the bus together.
// Parameters:
//   NUM_SRC   number of requesters (2..23), mapped to grant[NUM_SRC-1:0]
//   MAX_HOLD  max consecutive GRANT cycles before forced release (>=1)
//   CNT_W     hold counter width, 2**CNT_W >= MAX_HOLD
// Ports:
//   clk        in   1        system clock, rising edge
//   clr        in   1        asynchronous reset, active-low
//   req        in   NUM_SRC  per-source request, level-sensitive
//   lock       in   1        owner keeps the bus beyond MAX_HOLD while high
//   grant      out  32       registered one-hot (or zero) drive select
//   owner      out  5        granted source index, valid when gnt_valid=1
//   gnt_valid  out  1        grant is non-zero
//   timeout    out  1        one-cycle pulse (during TURN) after a forced release
module bus_grant_arbiter
    import bus_grant_arbiter_pkg::*;
#(
    parameter int NUM_SRC  = 23,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_SRC-1:0]  req,
    input  logic                lock,
    output logic [GRANT_W-1:0]  grant,
    output logic [OWNER_W-1:0]  owner,
    output logic                gnt_valid,
    output logic                timeout
);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;

    logic [OWNER_W-1:0]  ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [GRANT_W-1:0]  grant_r;
    logic [OWNER_W-1:0]  owner_r;
    logic                gnt_valid_r;
    logic                timeout_r;

    logic [GRANT_W-1:0]  grant_d_s;
    logic [OWNER_W-1:0]  owner_d_s;
    logic                gnt_valid_d_s;
    logic                timeout_d_s;
    logic [OWNER_W-1:0]  ptr_d_s;
    logic [CNT_W-1:0]    cnt_d_s;

    logic [OWNER_W-1:0]  pick_idx_s;
    logic                pick_found_s;
    logic                owner_req_s;
    logic                hold_done_s;
    logic                force_rel_s;
    logic                release_s;

    bus_grant_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // In GRANT the grant word is one-hot on the owner, so masking req with it
    // yields req[owner] without a variable-width bit select.
    assign owner_req_s = |(req & grant_r[NUM_SRC-1:0]);
    // ">=" rather than "==" so a lock that falls after the limit still releases.
    assign hold_done_s = (cnt_r >= CNT_W'(MAX_HOLD - 1));
    assign force_rel_s = owner_req_s && !lock && hold_done_s;
    assign release_s   = !owner_req_s || force_rel_s;

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nxt_s = ST_TURN;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_TURN: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; owner is left untouched outside GRANT
    // since it is only meaningful while gnt_valid is high.
    always_comb begin
        grant_d_s     = grant_r;
        owner_d_s     = owner_r;
        gnt_valid_d_s = gnt_valid_r;
        timeout_d_s   = 1'b0;
        ptr_d_s       = ptr_r;
        cnt_d_s       = cnt_r;
        case (state_r)
            ST_IDLE, ST_TURN: begin
                if (pick_found_s) begin
                    grant_d_s     = onehot_grant(pick_idx_s);
                    owner_d_s     = pick_idx_s;
                    gnt_valid_d_s = 1'b1;
                    cnt_d_s       = {CNT_W{1'b0}};
                end else begin
                    grant_d_s     = {GRANT_W{1'b0}};
                    gnt_valid_d_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    grant_d_s     = {GRANT_W{1'b0}};
                    gnt_valid_d_s = 1'b0;
                    timeout_d_s   = force_rel_s;
                    // Pointer moves past the releasing owner, wrapping at NUM_SRC.
                    if (owner_r == OWNER_W'(NUM_SRC - 1)) begin
                        ptr_d_s = {OWNER_W{1'b0}};
                    end else begin
                        ptr_d_s = owner_r + 5'd1;
                    end
                end else begin
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_d_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d_s = cnt_r;
                    end
                end
            end
            default: begin
                grant_d_s     = {GRANT_W{1'b0}};
                gnt_valid_d_s = 1'b0;
            end
        endcase
    end

    // Registered outputs, round-robin pointer and hold counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            grant_r     <= {GRANT_W{1'b0}};
            owner_r     <= NO_DRIVER;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            ptr_r       <= {OWNER_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            grant_r     <= grant_d_s;
            owner_r     <= owner_d_s;
            gnt_valid_r <= gnt_valid_d_s;
            timeout_r   <= timeout_d_s;
            ptr_r       <= ptr_d_s;
            cnt_r       <= cnt_d_s;
        end
    end

    assign grant     = grant_r;
    assign owner     = owner_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter (default parameters:
// NUM_SRC=23, MAX_HOLD=4). A cycle table covers reset, round-robin rotation,
// forced release and voluntary release; hand sequences cover lock, pointer
// wrap and asynchronous reset in the middle of a grant.
module tb_bus_grant_arbiter;

    logic        clk;
    logic        clr;
    logic [22:0] req;
    logic        lock;
    logic [31:0] grant;
    logic [4:0]  owner;
    logic        gnt_valid;
    logic        timeout;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic        clr;
        logic [22:0] req;
        logic        lock;
        logic [31:0] g;
        logic [4:0]  o;
        logic        v;
        logic        t;
    } vec_t;

    vec_t vq[$];

    bus_grant_arbiter dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .lock      (lock),
        .grant     (grant),
        .owner     (owner),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic c, input logic [22:0] r, input logic [31:0] g,
                        input logic [4:0] o, input logic v, input logic t);
        vec_t e;
        e.clr  = c;
        e.req  = r;
        e.lock = 1'b0;
        e.g    = g;
        e.o    = o;
        e.v    = v;
        e.t    = t;
        vq.push_back(e);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clr  = 1'b0;
        req  = 23'h0;
        lock = 1'b0;

        // Outputs in reset before any clock edge.
        #1;
        check("reset grant", grant, 32'h0);
        check("reset valid", {31'h0, gnt_valid}, 32'h0);

        // Test 1: reset with all requests, then rotation after forced release.
        addv(1'b0, 23'h7FFFFF, 32'h0, 5'd0, 1'b0, 1'b0);
        addv(1'b1, 23'h7FFFFF, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h7FFFFF, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h7FFFFF, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h7FFFFF, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h7FFFFF, 32'h0, 5'd0, 1'b0, 1'b1);
        addv(1'b1, 23'h7FFFFF, 32'h2, 5'd1, 1'b1, 1'b0);
        // Test 2: req=5 alternates 0 and 2 with timeouts and a TURN gap.
        addv(1'b0, 23'h5, 32'h0, 5'd0, 1'b0, 1'b0);
        addv(1'b1, 23'h5, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h1, 5'd0, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h0, 5'd0, 1'b0, 1'b1);
        addv(1'b1, 23'h5, 32'h4, 5'd2, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h4, 5'd2, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h4, 5'd2, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h4, 5'd2, 1'b1, 1'b0);
        addv(1'b1, 23'h5, 32'h0, 5'd0, 1'b0, 1'b1);
        addv(1'b1, 23'h5, 32'h1, 5'd0, 1'b1, 1'b0);
        // Test 3: sole requester drops after two grant cycles; no timeout, back to IDLE.
        addv(1'b0, 23'h8, 32'h0, 5'd0, 1'b0, 1'b0);
        addv(1'b1, 23'h8, 32'h8, 5'd3, 1'b1, 1'b0);
        addv(1'b1, 23'h8, 32'h8, 5'd3, 1'b1, 1'b0);
        addv(1'b1, 23'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        addv(1'b1, 23'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        addv(1'b1, 23'h0, 32'h0, 5'd0, 1'b0, 1'b0);

        #3;
        for (int i = 0; i < vq.size(); i++) begin
            clr  = vq[i].clr;
            req  = vq[i].req;
            lock = vq[i].lock;
            tick();
            check($sformatf("v%0d grant", i), grant, vq[i].g);
            check($sformatf("v%0d valid", i), {31'h0, gnt_valid}, {31'h0, vq[i].v});
            check($sformatf("v%0d timeout", i), {31'h0, timeout}, {31'h0, vq[i].t});
            if (vq[i].v) begin
                check($sformatf("v%0d owner", i), {27'h0, owner}, {27'h0, vq[i].o});
            end else begin
                total_cnt = total_cnt;
            end
        end

        // Test 4: lock holds the bus past MAX_HOLD; release when lock falls.
        clr = 1'b0;
        tick();
        clr  = 1'b1;
        req  = 23'h3;
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("lock hold grant c%0d", i), grant, 32'h1);
            check($sformatf("lock hold timeout c%0d", i), {31'h0, timeout}, 32'h0);
        end
        lock = 1'b0;
        tick();
        check("lock fall grant", grant, 32'h0);
        check("lock fall timeout", {31'h0, timeout}, 32'h1);
        tick();
        check("after lock grant", grant, 32'h2);
        check("after lock owner", {27'h0, owner}, 32'd1);
        check("after lock timeout", {31'h0, timeout}, 32'h0);

        // Test 5: owner 22 releases, pointer wraps to 0, source 1 wins.
        clr = 1'b0;
        req = 23'h400000;
        tick();
        clr = 1'b1;
        tick();
        check("wrap first grant", grant, 32'h400000);
        check("wrap first owner", {27'h0, owner}, 32'd22);
        req = 23'h400002;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wrap hold c%0d", i), grant, 32'h400000);
        end
        tick();
        check("wrap release grant", grant, 32'h0);
        check("wrap release timeout", {31'h0, timeout}, 32'h1);
        tick();
        check("wrap next grant", grant, 32'h2);
        check("wrap next owner", {27'h0, owner}, 32'd1);

        // Test 6: leave ptr non-zero, then async reset in the middle of a grant.
        req = 23'h0;
        tick();
        check("drop release timeout", {31'h0, timeout}, 32'h0);
        tick();
        check("idle grant", grant, 32'h0);
        req = 23'h10;
        tick();
        check("pre-clr grant", grant, 32'h10);
        check("pre-clr owner", {27'h0, owner}, 32'd4);
        #2;
        clr = 1'b0;
        #1;
        check("async clr grant", grant, 32'h0);
        check("async clr valid", {31'h0, gnt_valid}, 32'h0);
        req = 23'h11;
        tick();
        check("in clr grant", grant, 32'h0);
        clr = 1'b1;
        tick();
        check("post clr grant", grant, 32'h1);
        check("post clr owner", {27'h0, owner}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
